// File: rtl/rotation_scheduler.sv
`default_nettype none
// ============================================================================
// rotation_scheduler: queues corner descriptors and runs one rotation per
// corner, holding each coordinate-tagged result until downstream takes it.
// Revision: 1.0
// ============================================================================
module rotation_scheduler #(
   parameter int BW_TRIGONOMETRY = 11,
   parameter int BW_COORD        = 10,
   parameter int DEPTH_LOG2      = 2,
   parameter int TIMEOUT         = 15
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              ena_clk,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic signed [BW_TRIGONOMETRY-1:0] in_sin,
   input  logic signed [BW_TRIGONOMETRY-1:0] in_cos,
   input  logic        [BW_COORD-1:0]        in_x,
   input  logic        [BW_COORD-1:0]        in_y,
   output logic                              rot_ena,
   output logic signed [BW_TRIGONOMETRY-1:0] rot_sin,
   output logic signed [BW_TRIGONOMETRY-1:0] rot_cos,
   input  logic                              rot_valid,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic        [BW_COORD-1:0]        out_x,
   output logic        [BW_COORD-1:0]        out_y,
   output logic                              busy,
   output logic        [1:0]                 err
);

   localparam int c_DEPTH   = 1 << DEPTH_LOG2;
   localparam int c_ENTRY_W = 2 * BW_COORD + 2 * BW_TRIGONOMETRY;
   localparam int c_WAIT_W  = $clog2(TIMEOUT + 1);

   localparam logic [DEPTH_LOG2:0]   c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);
   localparam logic [DEPTH_LOG2:0]   c_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);
   localparam logic [c_WAIT_W-1:0]   c_WAIT_ONE  = c_WAIT_W'(1);
   localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_HOLD  = 2'd3;

   logic [1:0]                 state_q, state_d;
   logic [c_ENTRY_W-1:0]       mem_q [c_DEPTH];
   logic [DEPTH_LOG2-1:0]      wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]        count_q;
   logic [c_WAIT_W-1:0]        wait_cnt_q;
   logic [BW_TRIGONOMETRY-1:0] rot_sin_q, rot_cos_q;
   logic [BW_COORD-1:0]        out_x_q, out_y_q;
   logic [1:0]                 err_q;

   logic w_full, w_empty, w_push, w_pop, w_timeout;

   assign w_full    = (count_q == c_FULL);
   assign w_empty   = (count_q == '0);
   assign w_push    = in_valid && !w_full;
   assign w_pop     = (state_q == c_IDLE) && !w_empty;
   assign w_timeout = (wait_cnt_q == c_WAIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_IDLE;
      end else if (ena_clk) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:  if (!w_empty) state_d = c_ISSUE;
         c_ISSUE: state_d = c_WAIT;
         c_WAIT: begin
            // a late result on the timeout cycle still wins
            if (rot_valid)      state_d = c_HOLD;
            else if (w_timeout) state_d = c_IDLE;
         end
         c_HOLD:  if (out_ready) state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      rot_ena   = (state_q == c_ISSUE);
      out_valid = (state_q == c_HOLD);
      busy      = (state_q != c_IDLE) || !w_empty;
      in_ready  = !w_full;
   end

   always_ff @(posedge clk) begin
      if (ena_clk && w_push) begin
         mem_q[wptr_q] <= {in_x, in_y, in_sin, in_cos};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         wait_cnt_q <= '0;
         rot_sin_q  <= '0;
         rot_cos_q  <= '0;
         out_x_q    <= '0;
         out_y_q    <= '0;
         err_q      <= '0;
      end else if (ena_clk) begin
         if (w_push) wptr_q <= wptr_q + c_PTR_ONE;
         if (w_pop) begin
            rptr_q <= rptr_q + c_PTR_ONE;
            {out_x_q, out_y_q, rot_sin_q, rot_cos_q} <= mem_q[rptr_q];
         end
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + c_CNT_ONE;
            2'b01:   count_q <= count_q - c_CNT_ONE;
            default: count_q <= count_q;
         endcase
         if (state_q == c_ISSUE)     wait_cnt_q <= '0;
         else if (state_q == c_WAIT) wait_cnt_q <= wait_cnt_q + c_WAIT_ONE;
         if (state_q == c_WAIT && !rot_valid && w_timeout) err_q[0] <= 1'b1;
         if (state_q != c_WAIT && rot_valid)               err_q[1] <= 1'b1;
      end
   end

   assign rot_sin = rot_sin_q;
   assign rot_cos = rot_cos_q;
   assign out_x   = out_x_q;
   assign out_y   = out_y_q;
   assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rotation_scheduler.sv
`default_nettype none
// ============================================================================
// tb_rotation_scheduler: directed and randomized checks of rotation_scheduler.
// Revision: 1.0
// ============================================================================
module tb_rotation_scheduler;

   localparam int c_BWT   = 11;
   localparam int c_BWC   = 10;
   localparam int c_DEPTH = 4;
   localparam int c_TO    = 15;

   typedef struct packed {
      logic [c_BWC-1:0] x;
      logic [c_BWC-1:0] y;
      logic [c_BWT-1:0] s;
      logic [c_BWT-1:0] c;
   } desc_t;

   logic             clk = 1'b0;
   logic             rst, ena_clk, in_valid, in_ready;
   logic [c_BWT-1:0] in_sin, in_cos, rot_sin, rot_cos;
   logic [c_BWC-1:0] in_x, in_y, out_x, out_y;
   logic             rot_ena, rot_valid, out_valid, out_ready, busy;
   logic [1:0]       err;
   logic             rsp_valid, man_valid, rsp_en;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   assign rot_valid = rsp_valid | man_valid;

   rotation_scheduler #(
      .BW_TRIGONOMETRY(c_BWT), .BW_COORD(c_BWC), .DEPTH_LOG2(2), .TIMEOUT(c_TO)
   ) dut (
      .clk(clk), .rst(rst), .ena_clk(ena_clk),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sin(in_sin), .in_cos(in_cos), .in_x(in_x), .in_y(in_y),
      .rot_ena(rot_ena), .rot_sin(rot_sin), .rot_cos(rot_cos), .rot_valid(rot_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // rotation unit model: result pulse 8 cycles after the enable cycle
   initial begin
      int due;
      bit pending;
      rsp_valid = 1'b0;
      pending   = 1'b0;
      due       = 0;
      forever begin
         @(posedge clk); #1;
         rsp_valid = 1'b0;
         if (pending && cyc == due) begin
            rsp_valid = 1'b1;
            pending   = 1'b0;
         end
         if (rot_ena && rsp_en) begin
            pending = 1'b1;
            due     = cyc + 8;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input desc_t d);
      in_x = d.x; in_y = d.y; in_sin = d.s; in_cos = d.c;
   endtask

   task automatic wait_ena(input string tag);
      int k = 0;
      while (rot_ena !== 1'b1 && k < 40) begin tick(); k++; end
      check(tag, 32'(rot_ena), 32'd1);
   endtask

   task automatic wait_ov(input string tag);
      int k = 0;
      while (out_valid !== 1'b1 && k < 40) begin tick(); k++; end
      check(tag, 32'(out_valid), 32'd1);
   endtask

   initial begin
      desc_t d, da, dt, dn, df, dg;
      desc_t bq [5];
      desc_t exp_q [$];
      int    got, issued, last_ena, ena_cyc, occ;
      bit    inflight, exp_push, exp_acc, exp_ena, seen_ena, seen_ov;

      rst = 1'b1; ena_clk = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      man_valid = 1'b0; rsp_en = 1'b0;
      in_x = '0; in_y = '0; in_sin = '0; in_cos = '0;

      // reset values
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_rot_ena", 32'(rot_ena), 32'd0);
      check("rst_rot_sin", 32'(rot_sin), 32'd0);
      check("rst_rot_cos", 32'(rot_cos), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_xy", {out_x, out_y}, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();

      // single corner with latency checks
      rsp_en = 1'b1;
      d = '{x: 10'd100, y: 10'd37, s: 11'h0B5, c: 11'h2D4};
      drive(d); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      check("one_busy", 32'(busy), 32'd1);
      check("one_ena_early", 32'(rot_ena), 32'd0);
      tick();
      check("one_ena", 32'(rot_ena), 32'd1);
      check("one_sin", 32'(rot_sin), 32'h0B5);
      check("one_cos", 32'(rot_cos), 32'h2D4);
      tick();
      check("one_ena_pulse", 32'(rot_ena), 32'd0);
      repeat (7) tick();
      check("one_ov_early", 32'(out_valid), 32'd0);
      tick();
      check("one_ov", 32'(out_valid), 32'd1);
      check("one_x", 32'(out_x), 32'd100);
      check("one_y", 32'(out_y), 32'd37);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      check("one_ov_done", 32'(out_valid), 32'd0);
      check("one_busy_done", 32'(busy), 32'd0);

      // burst of five behind a held result, then backpressure
      da = '{x: 10'd1, y: 10'd2, s: 11'h011, c: 11'h022};
      drive(da); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      wait_ov("bp_a_ov");
      for (int k = 0; k < 5; k++) begin
         bq[k] = '{x: 10'(50 + k), y: 10'(900 - k), s: 11'(k * 300 + 7), c: 11'(2047 - k * 77)};
         drive(bq[k]); in_valid = 1'b1;
         check($sformatf("burst_in_ready%0d", k), 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         check("bp_ov_hold", 32'(out_valid), 32'd1);
         check("bp_no_ena", 32'(rot_ena), 32'd0);
         check("bp_full", 32'(in_ready), 32'd0);
         tick();
      end
      check("bp_a_xy", {out_x, out_y}, {12'd0, da.x, da.y});
      out_ready = 1'b1;
      tick();
      check("bp_ov_acc", 32'(out_valid), 32'd0);
      check("bp_still_full", 32'(in_ready), 32'd0);
      tick();
      check("burst_first_ena", 32'(rot_ena), 32'd1);
      check("burst_ready_again", 32'(in_ready), 32'd1);
      check("burst_sin0", 32'(rot_sin), 32'(bq[0].s));
      last_ena = cyc; issued = 1; got = 0;
      for (int k = 0; k < 80 && got < 4; k++) begin
         tick();
         if (rot_ena) begin
            check("burst_ena_gap", 32'(cyc - last_ena >= 3), 32'd1);
            check("burst_sin", 32'(rot_sin), 32'(bq[issued].s));
            check("burst_cos", 32'(rot_cos), 32'(bq[issued].c));
            last_ena = cyc; issued++;
         end
         if (out_valid) begin
            check("burst_xy", {out_x, out_y}, {12'd0, bq[got].x, bq[got].y});
            got++;
         end
      end
      check("burst_count", 32'(got), 32'd4);
      tick();

      // timeout on the first corner, second corner runs normally
      rsp_en = 1'b0;
      dt = '{x: 10'd200, y: 10'd300, s: 11'h123, c: 11'h456};
      dn = '{x: 10'd7, y: 10'd8, s: 11'h7AA, c: 11'h055};
      drive(dt); in_valid = 1'b1; tick();
      drive(dn); tick();
      in_valid = 1'b0;
      wait_ena("to_ena");
      check("to_sin", 32'(rot_sin), 32'(dt.s));
      seen_ov = 1'b0;
      for (int k = 1; k <= c_TO + 1; k++) begin
         tick();
         seen_ov |= out_valid;
         if (k == c_TO)     check("to_err_early", 32'(err[0]), 32'd0);
         if (k == c_TO + 1) check("to_err", 32'(err[0]), 32'd1);
      end
      check("to_no_ov", 32'(seen_ov), 32'd0);
      rsp_en = 1'b1;
      tick();
      check("to_next_ena", 32'(rot_ena), 32'd1);
      check("to_next_sin", 32'(rot_sin), 32'(dn.s));
      wait_ov("to_next_ov");
      check("to_next_xy", {out_x, out_y}, {12'd0, dn.x, dn.y});
      tick();

      // spurious result pulse while idle, cleared by reset
      man_valid = 1'b1;
      tick(); man_valid = 1'b0;
      check("spur_err", 32'(err), 32'd3);
      check("spur_idle", 32'(busy), 32'd0);
      tick();
      check("spur_no_ena", 32'(rot_ena), 32'd0);
      rst = 1'b1; tick(); rst = 1'b0;
      check("spur_rst_err", 32'(err), 32'd0);

      // clock-enable freeze during WAIT, then reset while holding
      rsp_en = 1'b0; out_ready = 1'b0;
      df = '{x: 10'd511, y: 10'd12, s: 11'h400, c: 11'h3FF};
      dg = '{x: 10'd3, y: 10'd4, s: 11'h005, c: 11'h006};
      drive(df); in_valid = 1'b1; tick();
      drive(dg); tick();
      in_valid = 1'b0;
      wait_ena("frz_ena");
      tick(); tick();
      ena_clk = 1'b0; man_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("frz_ov", 32'(out_valid), 32'd0);
         check("frz_err", 32'(err), 32'd0);
         check("frz_busy", 32'(busy), 32'd1);
      end
      ena_clk = 1'b1;
      tick(); man_valid = 1'b0;
      check("frz_hold", 32'(out_valid), 32'd1);
      check("frz_xy", {out_x, out_y}, {12'd0, df.x, df.y});
      check("frz_err_after", 32'(err), 32'd0);
      rst = 1'b1; tick(); rst = 1'b0;
      check("hrst_ov", 32'(out_valid), 32'd0);
      check("hrst_ready", 32'(in_ready), 32'd1);
      check("hrst_busy", 32'(busy), 32'd0);
      seen_ena = 1'b0; seen_ov = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         seen_ena |= rot_ena; seen_ov |= out_valid;
      end
      check("hrst_no_replay", {30'd0, seen_ena, seen_ov}, 32'd0);

      // randomized traffic against a transaction-level model
      rsp_en = 1'b1; inflight = 1'b0; ena_cyc = -100;
      for (int i = 0; i < 700; i++) begin
         d = '{x: 10'($urandom), y: 10'($urandom), s: 11'($urandom), c: 11'($urandom)};
         drive(d);
         in_valid  = (i < 600) && ($urandom_range(0, 2) != 0);
         out_ready = (i >= 600) || ($urandom_range(0, 3) != 0);
         occ = exp_q.size() - int'(inflight);
         check("rnd_in_ready", 32'(in_ready), 32'(occ < c_DEPTH));
         exp_push = in_valid && (occ < c_DEPTH);
         exp_acc  = inflight && (cyc - ena_cyc >= 9) && out_ready;
         exp_ena  = !inflight && (occ > 0);
         tick();
         if (exp_acc) begin
            void'(exp_q.pop_front());
            inflight = 1'b0;
         end
         check("rnd_rot_ena", 32'(rot_ena), 32'(exp_ena));
         if (exp_ena) begin
            check("rnd_sincos", {10'd0, rot_sin, rot_cos}, {10'd0, exp_q[0].s, exp_q[0].c});
            inflight = 1'b1;
            ena_cyc  = cyc;
         end
         if (exp_push) exp_q.push_back(d);
         check("rnd_out_valid", 32'(out_valid), 32'(inflight && (cyc - ena_cyc >= 9)));
         if (inflight && (cyc - ena_cyc >= 9))
            check("rnd_out_xy", {out_x, out_y}, {12'd0, exp_q[0].x, exp_q[0].y});
         check("rnd_busy", 32'(busy), 32'(inflight || exp_q.size() > 0));
      end
      check("rnd_drained", 32'(busy), 32'd0);
      check("rnd_err", 32'(err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
